bp_me_mem_cmd_arbiter: RTL and testbench
========================================

// Module: bp_me_mem_cmd_arbiter
// PURPOSE
//  Shares one BedRock memory command/response channel between num_req_p cache engines (e.g. I$ UCE, D$ UCE).
//  Arbitrates commands, records each grantee's id in an in-order tracking FIFO and steers each returning
//  response to that requester. Sits between the per-cache UCEs and the memory/uncore port.
// PARAMETERS
//  num_req_p      2    number of requesters (>=2)
//  msg_width_p    128  width of one cmd/resp message (cce_mem_msg_width_lp at instantiation)
//  max_out_p      4    max outstanding commands; tracking FIFO depth (power of 2)
// PORTS
//  clk_i          in   1                        sole clock
//  reset_n_i      in   1                        reset: synchronous, active-low
//  cmd_i          in   num_req_p*msg_width_p    requester commands, slot i = bits [i*msg_width_p +: msg_width_p]
//  cmd_v_i        in   num_req_p                requester command valid
//  cmd_ready_o    out  num_req_p                per-requester accept (ready-valid)
//  mem_cmd_o      out  msg_width_p              command to memory
//  mem_cmd_v_o    out  1                        command valid to memory
//  mem_cmd_ready_i in  1                        memory ready (ready-valid)
//  mem_resp_i     in   msg_width_p              response from memory
//  mem_resp_v_i   in   1                        response valid
//  mem_resp_yumi_o out 1                        response consumed (valid-yumi)
//  resp_o         out  msg_width_p              response broadcast to all requesters
//  resp_v_o       out  num_req_p                one-hot response valid
//  resp_yumi_i    in   num_req_p                requester consumes response
//  outstanding_o  out  clog2(max_out_p+1)       commands sent, response not yet returned
//  err_o          out  1                        sticky: response arrived with nothing outstanding
// BEHAVIOUR
//  - Reset (reset_n_i==0 at posedge): FIFO emptied, outstanding_o=0, err_o=0, priority pointer=0.
//    While in reset: cmd_ready_o=0, mem_cmd_v_o=0, resp_v_o=0, mem_resp_yumi_o=0.
//  - Arbitration: grant = one-hot among cmd_v_i per CONFIGURATION policy; grant is combinational, 0-cycle latency.
//    mem_cmd_o = cmd_i[grant slot]; mem_cmd_v_o = |cmd_v_i & ~full. No command while full.
//  - Send fires when mem_cmd_v_o & mem_cmd_ready_i: cmd_ready_o[g]=1 for grantee only; grantee id pushed to FIFO.
//    cmd_ready_o depends on cmd_v_i and mem_cmd_ready_i (combinational path accepted; requesters must not
//    make cmd_v_i depend on cmd_ready_o).
//  - Response: if FIFO non-empty, resp_v_o = onehot(FIFO head) & {num_req_p{mem_resp_v_i}};
//    mem_resp_yumi_o = |(resp_v_o & resp_yumi_i); FIFO pops on that yumi. Responses return in command order.
//  - Stray response (mem_resp_v_i & FIFO empty): consumed same cycle (mem_resp_yumi_o=1), resp_v_o=0, err_o set
//    next cycle and held until reset.
//  - Full: outstanding_o==max_out_p blocks all sends, even if a pop occurs the same cycle (no full-bypass).
//  - Empty: a response cannot bypass a send in the same cycle; a send's response is routable from the next cycle.
//  - Simultaneous send+pop: outstanding_o unchanged; FIFO pointers wrap modulo max_out_p.
//  - Requester holding cmd_v_i ungranted keeps its data stable; no requester starves under round-robin.
// CONFIGURATION
//  BP_ME_MEM_ARB_ROUND_ROBIN_EN defined: round-robin; pointer advances to (grantee+1) mod num_req_p on each
//    send; search starts at pointer. Pointer unchanged on cycles with no send.
//  Undefined: fixed priority, lowest index wins; pointer logic not built.
// STRUCTURE
//  - Shared package bp_me_pkg: requester-id width localparam (`BSG_SAFE_CLOG2(num_req_p)`), arbiter policy enum.
//  - One sub-module: bp_me_mem_arb_tracker (id FIFO + outstanding counter + err flag); arbitration stays in top.
//  - Reuse bsg_arb_round_robin / bsg_priority_encode and bsg_mux for grant and command select.
// TESTING
//  1 Reset: hold reset_n_i=0 3 cycles with cmd_v_i=2'b11, mem_resp_v_i=1 -> all valids/readies 0, outstanding_o=0, err_o=0.
//  2 RR contention (macro on): cmd_v_i=2'b11 held, mem_cmd_ready_i=1 -> grants 0,1,0,1; outstanding_o 1..4 then
//    sends stop at max_out_p=4 until a response pops.
//  3 Fixed priority (macro off): cmd_v_i=2'b11 -> requester 0 granted every cycle; 1 only when cmd_v_i[0]=0.
//  4 Routing: send from 1 then 0; return resps A,B -> resp_v_o=2'b10 with A, then 2'b01 with B; yumi withheld
//    2 cycles -> mem_resp_yumi_o=0 and resp_o stable until yumi.
//  5 Full + simultaneous pop: outstanding_o=4, pop and cmd_v_i=1 same cycle -> no send, outstanding_o=3; send next cycle.
//  6 Stray: FIFO empty, mem_resp_v_i=1 -> mem_resp_yumi_o=1, resp_v_o=0, err_o=1 from next cycle until reset.

Source files
------------

// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared arbiter policy enum and id-width helper; policy follows BP_ME_MEM_ARB_ROUND_ROBIN_EN
package bp_me_pkg;
  typedef enum logic {ARB_FIXED, ARB_ROUND_ROBIN} arb_policy_e;
`ifdef BP_ME_MEM_ARB_ROUND_ROBIN_EN
  localparam arb_policy_e arb_policy_lp = ARB_ROUND_ROBIN;
`else
  localparam arb_policy_e arb_policy_lp = ARB_FIXED;
`endif
  function automatic int safe_clog2(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bp_me_mem_cmd_arbiter_if.sv
// bp_me_mem_cmd_arbiter_if: requester/memory handshake bundle of the memory command arbiter
interface bp_me_mem_cmd_arbiter_if #(
  parameter int num_req_p   = 2,
  parameter int msg_width_p = 128,
  parameter int max_out_p   = 4
);
  localparam int out_width_lp = $clog2(max_out_p + 1);
  logic [num_req_p*msg_width_p-1:0] cmd_i;
  logic [num_req_p-1:0]             cmd_v_i;
  logic [num_req_p-1:0]             cmd_ready_o;
  logic [msg_width_p-1:0]           mem_cmd_o;
  logic                             mem_cmd_v_o;
  logic                             mem_cmd_ready_i;
  logic [msg_width_p-1:0]           mem_resp_i;
  logic                             mem_resp_v_i;
  logic                             mem_resp_yumi_o;
  logic [msg_width_p-1:0]           resp_o;
  logic [num_req_p-1:0]             resp_v_o;
  logic [num_req_p-1:0]             resp_yumi_i;
  logic [out_width_lp-1:0]          outstanding_o;
  logic                             err_o;
  modport slave (
    input  cmd_i, cmd_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, resp_yumi_i,
    output cmd_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, resp_o, resp_v_o, outstanding_o, err_o
  );
  modport master (
    output cmd_i, cmd_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, resp_yumi_i,
    input  cmd_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, resp_o, resp_v_o, outstanding_o, err_o
  );
endinterface

// File: rtl/bp_me_mem_arb_tracker.sv
// bp_me_mem_arb_tracker: in-order grantee id FIFO, outstanding counter and sticky stray-response flag
module bp_me_mem_arb_tracker
  import bp_me_pkg::*;
#(
  parameter int id_width_p   = 1,
  parameter int max_out_p    = 4,
  parameter int out_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    push_i,
  input  logic [id_width_p-1:0]   id_i,
  input  logic                    pop_i,
  input  logic                    stray_i,
  output logic [id_width_p-1:0]   head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [out_width_lp-1:0] count_o,
  output logic                    err_o
);
  localparam int ptr_width_lp = safe_clog2(max_out_p);
  logic [id_width_p-1:0]   ids [max_out_p];
  logic [ptr_width_lp-1:0] wptr, rptr;
  function automatic logic [ptr_width_lp-1:0] nxt(logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(max_out_p - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (push_i) begin
        ids[wptr] <= id_i;
        wptr      <= nxt(wptr);
      end
      if (pop_i) rptr <= nxt(rptr);
      count_o <= count_o + out_width_lp'(push_i) - out_width_lp'(pop_i);
      err_o   <= err_o | stray_i;
    end
  end
  assign head_o  = ids[rptr];
  assign full_o  = count_o == out_width_lp'(max_out_p);
  assign empty_o = count_o == '0;
endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter: shares one memory cmd/resp channel among requesters, routing responses in order.
// Round-robin grant when BP_ME_MEM_ARB_ROUND_ROBIN_EN is defined, fixed lowest-index priority otherwise.
module bp_me_mem_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p   = 2,
  parameter int msg_width_p = 128,
  parameter int max_out_p   = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_me_mem_cmd_arbiter_if.slave bus
);
  localparam int id_width_lp = safe_clog2(num_req_p);
  logic [id_width_lp-1:0] ptr, start, gid, head;
  logic found, full, empty, send, pop, stray;
`ifdef BP_ME_MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) ptr <= '0;
    else if (send) ptr <= (gid == id_width_lp'(num_req_p - 1)) ? '0 : gid + 1'b1;
  end
`else
  assign ptr = '0;
`endif
  assign start = (arb_policy_lp == ARB_ROUND_ROBIN) ? ptr : '0;
  // first valid requester at or after start, wrapping
  always_comb begin
    gid   = '0;
    found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!found && bus.cmd_v_i[(int'(start) + i) % num_req_p]) begin
        gid   = id_width_lp'((int'(start) + i) % num_req_p);
        found = 1'b1;
      end
    end
  end
  assign bus.mem_cmd_o       = bus.cmd_i[gid*msg_width_p +: msg_width_p];
  assign bus.mem_cmd_v_o     = reset_n_i & found & ~full;
  assign send                = bus.mem_cmd_v_o & bus.mem_cmd_ready_i;
  assign bus.cmd_ready_o     = send ? num_req_p'(1) << gid : '0;
  assign bus.resp_o          = bus.mem_resp_i;
  assign bus.resp_v_o        = (reset_n_i & ~empty & bus.mem_resp_v_i) ? num_req_p'(1) << head : '0;
  assign pop                 = |(bus.resp_v_o & bus.resp_yumi_i);
  assign stray               = reset_n_i & empty & bus.mem_resp_v_i;
  assign bus.mem_resp_yumi_o = pop | stray;
  bp_me_mem_arb_tracker #(
    .id_width_p(id_width_lp),
    .max_out_p (max_out_p)
  ) tracker (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (send),
    .id_i     (gid),
    .pop_i    (pop),
    .stray_i  (stray),
    .head_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (bus.outstanding_o),
    .err_o    (bus.err_o)
  );
endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb_bp_me_mem_cmd_arbiter: directed plus random stimulus checked every cycle against a queue-based model
module tb_bp_me_mem_cmd_arbiter;
  localparam int N = 2, W = 128, MAX = 4;
`ifdef BP_ME_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  bp_me_mem_cmd_arbiter_if #(.num_req_p(N), .msg_width_p(W), .max_out_p(MAX)) bus();
  bp_me_mem_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_out_p(MAX)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
  );
  int total = 0, passed = 0;
  int q[$];
  bit err_m = 1'b0;
  int ptr_m = 0;
  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step(bit rn, logic [N-1:0] cv, logic mr, logic rv, logic [N-1:0] ym, logic [W-1:0] rd);
    logic [W-1:0] c0, c1;
    logic [N-1:0] erdy, erv;
    int g;
    bit mv, snd, pop, stray;
    @(negedge clk);
    c0 = {4{$urandom}};
    c1 = {4{$urandom}};
    reset_n = rn;
    bus.cmd_i = {c1, c0};
    bus.cmd_v_i = cv;
    bus.mem_cmd_ready_i = mr;
    bus.mem_resp_v_i = rv;
    bus.mem_resp_i = rd;
    bus.resp_yumi_i = ym;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = ((RR ? ptr_m : 0) + i) % N;
      if (g < 0 && cv[k]) g = k;
    end
    mv    = rn && g >= 0 && q.size() < MAX;
    snd   = mv && mr;
    erdy  = snd ? N'(1) << g : '0;
    erv   = (rn && q.size() > 0 && rv) ? N'(1) << q[0] : '0;
    pop   = |(erv & ym);
    stray = rn && q.size() == 0 && rv;
    chk("mem_cmd_v", bus.mem_cmd_v_o, mv);
    chk("cmd_ready", bus.cmd_ready_o, erdy);
    if (mv) chk("mem_cmd", bus.mem_cmd_o, g == 0 ? c0 : c1);
    chk("resp_v", bus.resp_v_o, erv);
    chk("mem_resp_yumi", bus.mem_resp_yumi_o, pop | stray);
    if (|erv) chk("resp_data", bus.resp_o, rd);
    chk("outstanding", bus.outstanding_o, q.size());
    chk("err", bus.err_o, err_m);
    if (!rn) begin
      q.delete();
      err_m = 1'b0;
      ptr_m = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (snd) begin
        q.push_back(g);
        ptr_m = (g + 1) % N;
      end
      if (stray) err_m = 1'b1;
    end
  endtask
  initial begin
    bus.cmd_i = '0; bus.cmd_v_i = '0; bus.mem_cmd_ready_i = 1'b0;
    bus.mem_resp_i = '0; bus.mem_resp_v_i = 1'b0; bus.resp_yumi_i = '0;
    for (int i = 0; i < 3; i++) step(0, 2'b11, 1, 1, 2'b11, 128'h55);
    chk("reset_cmd_v_lit", bus.mem_cmd_v_o, 0);
    chk("reset_ready_lit", bus.cmd_ready_o, 0);
    chk("reset_resp_v_lit", bus.resp_v_o, 0);
    chk("reset_yumi_lit", bus.mem_resp_yumi_o, 0);
    // contention: four sends fill the tracker
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b11, 1, 0, 0, '0);
      chk("contend_grant_lit", bus.cmd_ready_o, (RR && i % 2 == 1) ? 2'b10 : 2'b01);
      chk("contend_count_lit", bus.outstanding_o, i);
    end
    step(1, 2'b11, 1, 0, 0, '0);
    chk("full_count_lit", bus.outstanding_o, 4);
    chk("full_block_lit", bus.mem_cmd_v_o, 0);
    step(1, 2'b01, 1, 1, 2'b11, 128'h77);
    chk("full_pop_nosend_lit", bus.mem_cmd_v_o, 0);
    chk("full_pop_yumi_lit", bus.mem_resp_yumi_o, 1);
    step(1, 2'b01, 1, 0, 0, '0);
    chk("after_pop_count_lit", bus.outstanding_o, 3);
    chk("after_pop_send_lit", bus.cmd_ready_o, 2'b01);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1, 0, 0, 1, 2'b11, {4{$urandom}});
    // routing: send from 1 then 0, responses return in that order
    step(1, 2'b10, 1, 0, 0, '0);
    step(1, 2'b01, 1, 0, 0, '0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 1, 2'b00, 128'hA);
      chk("route_a_v_lit", bus.resp_v_o, 2'b10);
      chk("route_a_hold_lit", bus.mem_resp_yumi_o, 0);
      chk("route_a_data_lit", bus.resp_o, 128'hA);
    end
    step(1, 0, 0, 1, 2'b10, 128'hA);
    chk("route_a_yumi_lit", bus.mem_resp_yumi_o, 1);
    step(1, 0, 0, 1, 2'b01, 128'hB);
    chk("route_b_v_lit", bus.resp_v_o, 2'b01);
    chk("route_b_data_lit", bus.resp_o, 128'hB);
    for (int i = 0; i < 3000; i++) begin
      bit rn, rv;
      rn = $urandom_range(0, 199) != 0;
      rv = (q.size() > 0) ? bit'($urandom % 2) : ($urandom_range(0, 49) == 0);
      step(rn, N'($urandom), 1'($urandom), rv, N'($urandom), {4{$urandom}});
    end
    // stray response after a clean reset
    step(0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 1, 0, 128'h99);
    chk("stray_yumi_lit", bus.mem_resp_yumi_o, 1);
    chk("stray_resp_v_lit", bus.resp_v_o, 0);
    chk("stray_err_pre_lit", bus.err_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, '0);
      chk("stray_err_lit", bus.err_o, 1);
    end
    step(0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    chk("err_cleared_lit", bus.err_o, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
